// File: rtl/filter_read_ctrl_pkg.sv
// Shared types and constants for the filter scratchpad read controller.
// State encoding is fixed so it can be matched against other tooling.
package filter_read_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StRead  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Cycles from read_en to scratch_dout being valid.
  localparam int unsigned ReadLatency = 1;

endpackage

// File: rtl/filter_avail_check.sv
// Combinational availability test: is filter element elem_i already written?
// Uses modular distance from the filter base to the write pointer.
module filter_avail_check #(
  parameter int unsigned AddrWidth  = 8,
  parameter int unsigned CountWidth = 8
) (
  input  logic [AddrWidth-1:0]  last_write_i,
  input  logic [AddrWidth-1:0]  filter_base_i,
  input  logic [CountWidth-1:0] elem_i,
  output logic                  readable_o
);

  localparam int unsigned CmpWidth = (AddrWidth > CountWidth) ? AddrWidth : CountWidth;

  logic [AddrWidth-1:0] avail;

  always_comb begin
    // Wraps naturally: the subtraction is taken modulo 2^AddrWidth.
    avail      = last_write_i - filter_base_i;
    readable_o = CmpWidth'(elem_i) < CmpWidth'(avail);
  end

endmodule

// File: rtl/filter_read_ctrl.sv
// Filter scratchpad read controller: replays one filter num_windows times,
// issuing a read only once the word is written and the PE is ready.
module filter_read_ctrl
  import filter_read_ctrl_pkg::*;
#(
  parameter int unsigned SCRATCH_ADDRESS_SIZE = 8,
  parameter int unsigned SCRATCH_WIDTH        = 8,
  parameter int unsigned COUNT_WIDTH          = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [SCRATCH_ADDRESS_SIZE-1:0] filter_base,
  input  logic [COUNT_WIDTH-1:0]          filter_size,
  input  logic [COUNT_WIDTH-1:0]          num_windows,
  input  logic [SCRATCH_ADDRESS_SIZE-1:0] last_write,
  input  logic                            pe_ready,
  input  logic [SCRATCH_WIDTH-1:0]        scratch_dout,
  output logic [SCRATCH_ADDRESS_SIZE-1:0] read_addr,
  output logic                            read_en,
  output logic                            chip_en,
  output logic [SCRATCH_WIDTH-1:0]        w_data,
  output logic                            w_valid,
  output logic                            w_first,
  output logic                            w_last,
  output logic                            busy,
  output logic                            done
);

  state_e                          state_q, state_d;
  logic [SCRATCH_ADDRESS_SIZE-1:0] base_q, base_d;
  logic [COUNT_WIDTH-1:0]          size_q, size_d;
  logic [COUNT_WIDTH-1:0]          nwin_q, nwin_d;
  logic [COUNT_WIDTH-1:0]          elem_cnt_q, elem_cnt_d;
  logic [COUNT_WIDTH-1:0]          win_cnt_q, win_cnt_d;
  logic                            read_en_q, read_en_d;
  logic [SCRATCH_ADDRESS_SIZE-1:0] read_addr_q, read_addr_d;
  logic                            tag_first_q, tag_first_d;
  logic                            tag_last_q, tag_last_d;
  logic [ReadLatency-1:0]          vpipe_q, vpipe_d;
  logic [ReadLatency-1:0]          fpipe_q, fpipe_d;
  logic [ReadLatency-1:0]          lpipe_q, lpipe_d;

  logic                   elem_last;
  logic                   win_last;
  logic [COUNT_WIDTH-1:0] elem_next;
  logic [COUNT_WIDTH-1:0] check_elem;
  logic                   readable;

  always_comb begin
    elem_last  = (elem_cnt_q == size_q - COUNT_WIDTH'(1));
    win_last   = (win_cnt_q == nwin_q - COUNT_WIDTH'(1));
    elem_next  = elem_last ? '0 : elem_cnt_q + COUNT_WIDTH'(1);
    // In READ the decision is about the element after the one being read.
    check_elem = (state_q == StRead) ? elem_next : elem_cnt_q;
  end

  filter_avail_check #(
    .AddrWidth (SCRATCH_ADDRESS_SIZE),
    .CountWidth(COUNT_WIDTH)
  ) u_avail (
    .last_write_i (last_write),
    .filter_base_i(base_q),
    .elem_i       (check_elem),
    .readable_o   (readable)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    nwin_d     = nwin_q;
    elem_cnt_d = elem_cnt_q;
    win_cnt_d  = win_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (filter_size == '0 || num_windows == '0) begin
            state_d = StDone;
          end else begin
            base_d     = filter_base;
            size_d     = filter_size;
            nwin_d     = num_windows;
            elem_cnt_d = '0;
            win_cnt_d  = '0;
            state_d    = StCheck;
          end
        end
      end
      StCheck: begin
        if (readable && pe_ready) state_d = StRead;
      end
      StRead: begin
        elem_cnt_d = elem_next;
        if (elem_last) win_cnt_d = win_cnt_q + COUNT_WIDTH'(1);
        if (elem_last && win_last) begin
          state_d = StDrain;
        end else if (readable && pe_ready) begin
          state_d = StRead;
        end else begin
          state_d = StCheck;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    read_en_d   = (state_d == StRead);
    read_addr_d = read_addr_q;
    tag_first_d = 1'b0;
    tag_last_d  = 1'b0;
    if (read_en_d) begin
      read_addr_d = base_d + SCRATCH_ADDRESS_SIZE'(elem_cnt_d);
      tag_first_d = (elem_cnt_d == '0);
      tag_last_d  = (elem_cnt_d == size_d - COUNT_WIDTH'(1));
    end

    // Tags travel alongside the scratchpad read so they line up with dout.
    vpipe_d[0] = read_en_q;
    fpipe_d[0] = read_en_q & tag_first_q;
    lpipe_d[0] = read_en_q & tag_last_q;
    for (int unsigned i = 1; i < ReadLatency; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      fpipe_d[i] = fpipe_q[i-1];
      lpipe_d[i] = lpipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      size_q      <= '0;
      nwin_q      <= '0;
      elem_cnt_q  <= '0;
      win_cnt_q   <= '0;
      read_en_q   <= 1'b0;
      read_addr_q <= '0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
      vpipe_q     <= '0;
      fpipe_q     <= '0;
      lpipe_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      size_q      <= size_d;
      nwin_q      <= nwin_d;
      elem_cnt_q  <= elem_cnt_d;
      win_cnt_q   <= win_cnt_d;
      read_en_q   <= read_en_d;
      read_addr_q <= read_addr_d;
      tag_first_q <= tag_first_d;
      tag_last_q  <= tag_last_d;
      vpipe_q     <= vpipe_d;
      fpipe_q     <= fpipe_d;
      lpipe_q     <= lpipe_d;
    end
  end

  always_comb begin
    read_en   = read_en_q;
    read_addr = read_addr_q;
    chip_en   = (state_q != StIdle);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    w_valid   = vpipe_q[ReadLatency-1];
    w_first   = fpipe_q[ReadLatency-1];
    w_last    = lpipe_q[ReadLatency-1];
    // Scratchpad data is only presented to the PE in its valid cycle.
    w_data    = w_valid ? scratch_dout : '0;
  end

endmodule

// File: tb/tb_filter_read_ctrl.sv
// Self-checking bench for filter_read_ctrl: directed scenarios plus random jobs,
// checked against a word-stream model of the filter replay.
module tb_filter_read_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] filter_base, filter_size, num_windows, last_write;
  logic       pe_ready;
  logic [7:0] scratch_dout;
  logic [7:0] read_addr;
  logic       read_en, chip_en;
  logic [7:0] w_data;
  logic       w_valid, w_first, w_last, busy, done;

  always #5 clk = ~clk;

  filter_read_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .filter_base (filter_base),
    .filter_size (filter_size),
    .num_windows (num_windows),
    .last_write  (last_write),
    .pe_ready    (pe_ready),
    .scratch_dout(scratch_dout),
    .read_addr   (read_addr),
    .read_en     (read_en),
    .chip_en     (chip_en),
    .w_data      (w_data),
    .w_valid     (w_valid),
    .w_first     (w_first),
    .w_last      (w_last),
    .busy        (busy),
    .done        (done)
  );

  logic [7:0] mem [256];

  always @(posedge clk) if (read_en) scratch_dout <= mem[read_addr];

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } word_t;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_base, m_size, m_nwin;
  int         m_total, m_rd;
  word_t      exp_q[$];
  int         rd_cycles[$];
  logic [7:0] rd_addrs[$];
  int         cyc = 0;
  int         start_cyc, done_cyc, raise_cyc;
  logic       prev_rdy, prev_read_en = 1'b0;
  logic [7:0] prev_lw;
  int         rs, rn, rw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs set before the call are what the DUT samples at this edge.
  task automatic tick();
    int         e;
    logic [7:0] a, av;
    word_t      w;
    prev_rdy = pe_ready;
    prev_lw  = last_write;
    @(posedge clk);
    #1;
    cyc++;
    if (read_en) begin
      chk("rd_in_job", 32'(m_rd < m_total), 1);
      if (m_rd < m_total) begin
        e  = m_rd % int'(m_size);
        a  = m_base + 8'(e);
        av = prev_lw - m_base;
        chk("rd_addr", 32'(read_addr), 32'(a));
        chk("rd_ready", 32'(prev_rdy), 1);
        chk("rd_avail", 32'(e < int'(av)), 1);
        w.d = mem[a];
        w.f = (e == 0);
        w.l = (e == int'(m_size) - 1);
        exp_q.push_back(w);
        rd_cycles.push_back(cyc);
        rd_addrs.push_back(read_addr);
        m_rd++;
      end
    end
    chk("wv_latency", 32'(w_valid), 32'(prev_read_en));
    if (w_valid) begin
      chk("wv_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("w_data", 32'(w_data), 32'(w.d));
        chk("w_first", 32'(w_first), 32'(w.f));
        chk("w_last", 32'(w_last), 32'(w.l));
      end
    end else begin
      chk("tags_idle", 32'({w_first, w_last}), 0);
    end
    if (done) done_cyc = cyc;
    prev_read_en = read_en;
  endtask

  task automatic start_job(input logic [7:0] b, input logic [7:0] s, input logic [7:0] n,
                           input logic [7:0] lw);
    filter_base = b;
    filter_size = s;
    num_windows = n;
    last_write  = lw;
    pe_ready    = 1'b1;
    m_base  = b;
    m_size  = s;
    m_nwin  = n;
    m_total = int'(s) * int'(n);
    m_rd    = 0;
    exp_q.delete();
    rd_cycles.delete();
    rd_addrs.delete();
    done_cyc = -1;
    start    = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  // rdy_mode: 0 always ready, 1 toggling 1,0,1,0, 2 random.
  task automatic run_job(input logic [7:0] b, input logic [7:0] s, input logic [7:0] n,
                         input int wr_init, input int rdy_mode, input int raise_at,
                         input int busy_start_at);
    int wr;
    wr = wr_init;
    start_job(b, s, n, b + 8'(wr));
    for (int k = 0; k < 400 && done_cyc < 0; k++) begin
      if (raise_at >= 0) begin
        if (k == raise_at) raise_cyc = cyc;
        last_write = (k >= raise_at) ? b + s : b + 8'(wr_init);
      end else begin
        if (wr < int'(s) && $urandom_range(0, 2) == 0) wr++;
        last_write = b + 8'(wr);
      end
      case (rdy_mode)
        0:       pe_ready = 1'b1;
        1:       pe_ready = (k % 2 == 0);
        default: pe_ready = 1'($urandom_range(0, 1));
      endcase
      if (k == busy_start_at) begin
        start       = 1'b1;
        filter_base = 8'h77;
        filter_size = 8'd9;
        num_windows = 8'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("job_done_seen", 32'(done_cyc >= 0), 1);
    chk("job_reads", 32'(m_rd), 32'(m_total));
    chk("job_words_left", 32'(exp_q.size()), 0);
    if (m_total > 0 && rd_cycles.size() > 0)
      chk("done_latency", 32'(done_cyc - rd_cycles[rd_cycles.size()-1]), 2);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_done", 32'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1; start = 1'b0; filter_base = '0; filter_size = '0; num_windows = '0;
    last_write = '0; pe_ready = 1'b0;
    #12;
    chk("rst_read_en", 32'(read_en), 0);
    chk("rst_read_addr", 32'(read_addr), 0);
    chk("rst_chip_en", 32'(chip_en), 0);
    chk("rst_w_valid", 32'({w_valid, w_first, w_last}), 0);
    chk("rst_w_data", 32'(w_data), 0);
    chk("rst_busy_done", 32'({busy, done}), 0);
    rst = 1'b0;
    tick();

    // Basic job with a start pulse while busy that must be ignored.
    run_job(8'd0, 8'd4, 8'd2, 4, 0, -1, 3);
    chk("basic_reads", 32'(rd_addrs.size()), 8);
    if (rd_cycles.size() == 8) begin
      chk("basic_first_rd", 32'(rd_cycles[0] - start_cyc), 1);
      chk("basic_consecutive", 32'(rd_cycles[7] - rd_cycles[0]), 7);
      chk("basic_addr4", 32'(rd_addrs[4]), 0);
    end

    // Data not yet written: stall after element 0 until last_write reaches 3.
    run_job(8'd0, 8'd3, 8'd1, 1, 0, 8, -1);
    if (rd_cycles.size() >= 2) begin
      chk("stall_rd0", 32'(rd_cycles[0] - start_cyc), 1);
      chk("stall_rd1_after_raise", 32'(rd_cycles[1] - raise_cyc), 1);
    end else chk("stall_reads", 32'(rd_cycles.size()), 3);

    // Address wrap.
    run_job(8'd254, 8'd4, 8'd1, 4, 0, -1, -1);
    if (rd_addrs.size() == 4) begin
      chk("wrap_a0", 32'(rd_addrs[0]), 254);
      chk("wrap_a1", 32'(rd_addrs[1]), 255);
      chk("wrap_a2", 32'(rd_addrs[2]), 0);
      chk("wrap_a3", 32'(rd_addrs[3]), 1);
    end else chk("wrap_reads", 32'(rd_addrs.size()), 4);

    // Backpressure.
    run_job(8'd40, 8'd5, 8'd2, 5, 1, -1, -1);

    // Zero size and zero windows.
    run_job(8'd9, 8'd0, 8'd3, 0, 0, -1, -1);
    chk("zero_size_done", 32'(done_cyc - start_cyc), 0);
    run_job(8'd9, 8'd3, 8'd0, 3, 0, -1, -1);
    chk("zero_win_done", 32'(done_cyc - start_cyc), 0);

    // Reset during the third read.
    start_job(8'h20, 8'd5, 8'd2, 8'h25);
    for (int k = 0; k < 20 && m_rd < 3; k++) tick();
    chk("mid_third_read", 32'(m_rd), 3);
    rst = 1'b1;
    #1;
    chk("midrst_read_en", 32'(read_en), 0);
    chk("midrst_read_addr", 32'(read_addr), 0);
    chk("midrst_chip_en", 32'(chip_en), 0);
    chk("midrst_w", 32'({w_valid, w_first, w_last}), 0);
    chk("midrst_w_data", 32'(w_data), 0);
    chk("midrst_busy_done", 32'({busy, done}), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    prev_read_en = 1'b0;
    run_job(8'h20, 8'd5, 8'd2, 5, 0, -1, -1);
    if (rd_addrs.size() > 0) chk("restart_from_elem0", 32'(rd_addrs[0]), 32'h20);

    // Random jobs.
    for (int j = 0; j < 8; j++) begin
      rs = $urandom_range(1, 6);
      rn = $urandom_range(1, 3);
      rw = $urandom_range(0, rs);
      run_job(8'($urandom), 8'(rs), 8'(rn), rw, 2, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
